// File: rtl/memory_arbiter_pkg.sv
// Shared definitions for the coprocessor data-memory arbiter: FSM encoding,
// default geometry (N_REQ = p + 1) and the modulo-wrap helper.
package memory_arbiter_pkg;

  localparam int P_UNITS                 = 4;
  localparam int DEFAULT_N_REQ           = P_UNITS + 1;
  localparam int DEFAULT_MEMORY_SIZE_LOG = 10;
  localparam int DEFAULT_DATA_WIDTH      = 32;
  localparam int DEFAULT_MAX_HOLD        = 255;

  typedef enum logic [1:0] {
    s_Idle       = 2'd0,
    s_Granted    = 2'd1,
    s_Turnaround = 2'd2
  } arb_state_t;

  // idx is always below 2*n here, so one subtraction is a full modulo.
  function automatic int wrap_index(input int idx, input int n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester/memory bus of the shared data-memory arbiter.
// Handshake: i_Request[k] is a level held for the whole access; the access is
// live only while o_Grant[k] is high, and dropping i_Request[k] releases it.
interface memory_arbiter_if
  import memory_arbiter_pkg::*;
#(
  parameter int N_REQ           = DEFAULT_N_REQ,
  parameter int memory_size_log = DEFAULT_MEMORY_SIZE_LOG,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]                 i_Request;
  logic [N_REQ*memory_size_log-1:0] i_Address;
  logic [N_REQ-1:0]                 i_Write_Enable;
  logic [N_REQ*DATA_WIDTH-1:0]      i_Write_Data;
  logic [DATA_WIDTH-1:0]            i_Memory_Read_Data;

  logic [N_REQ-1:0]                 o_Grant;
  logic [memory_size_log-1:0]       o_Memory_Address;
  logic                             o_Memory_Write_Enable;
  logic [DATA_WIDTH-1:0]            o_Memory_Write_Data;
  logic [DATA_WIDTH-1:0]            o_Read_Data;
  logic                             o_Busy;
  logic [OW-1:0]                    o_Owner;
  logic                             o_Timeout;
  arb_state_t                       dbg_State;

  modport master (
    output i_Request, i_Address, i_Write_Enable, i_Write_Data, i_Memory_Read_Data,
    input  o_Grant, o_Memory_Address, o_Memory_Write_Enable, o_Memory_Write_Data,
    input  o_Read_Data, o_Busy, o_Owner, o_Timeout, dbg_State
  );

  modport slave (
    input  i_Request, i_Address, i_Write_Enable, i_Write_Data, i_Memory_Read_Data,
    output o_Grant, o_Memory_Address, o_Memory_Write_Enable, o_Memory_Write_Data,
    output o_Read_Data, o_Busy, o_Owner, o_Timeout, dbg_State
  );

endinterface

// File: rtl/memory_arbiter_rr_priority_picker.sv
// Combinational first-set search starting at a rotating pointer, with an
// optional override that lets requester 0 win whenever it asks.
module memory_arbiter_rr_priority_picker
  import memory_arbiter_pkg::*;
#(
  parameter int N_REQ      = DEFAULT_N_REQ,
  parameter int PRIORITY_0 = 1,
  parameter int OW         = 3
) (
  input  logic [N_REQ-1:0] i_Request,
  input  logic [OW-1:0]    i_Pointer,
  output logic [OW-1:0]    o_Winner,
  output logic             o_Valid
);

  int idx;

  always_comb begin
    o_Winner = '0;
    o_Valid  = 1'b0;
    idx      = 0;
    if ((PRIORITY_0 != 0) && i_Request[0]) begin
      o_Valid = 1'b1;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        idx = wrap_index(int'(i_Pointer) + i, N_REQ);
        if (!o_Valid && i_Request[idx]) begin
          o_Valid  = 1'b1;
          o_Winner = OW'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/memory_arbiter.sv
// Round-robin owner arbiter for the shared data memory: one registered grant,
// a one-cycle turnaround between owners and a sticky over-long-hold flag.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int N_REQ           = DEFAULT_N_REQ,
  parameter int memory_size_log = DEFAULT_MEMORY_SIZE_LOG,
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int PRIORITY_0      = 1,
  parameter int MAX_HOLD        = DEFAULT_MAX_HOLD
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  memory_arbiter_if.slave  bus
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_t                 state_q;
  logic [N_REQ-1:0]           grant_q;
  logic [OW-1:0]              owner_q;
  logic [OW-1:0]              ptr_q;
  logic [HW-1:0]              hold_q;
  logic                       timeout_q;

  logic [OW-1:0]              win;
  logic                       win_valid;
  logic                       owner_req;
  logic                       mux_we;
  logic [memory_size_log-1:0] mux_addr;
  logic [DATA_WIDTH-1:0]      mux_wd;
  logic                       granted;

  memory_arbiter_rr_priority_picker #(
    .N_REQ      (N_REQ),
    .PRIORITY_0 (PRIORITY_0),
    .OW         (OW)
  ) u_picker (
    .i_Request (bus.i_Request),
    .i_Pointer (ptr_q),
    .o_Winner  (win),
    .o_Valid   (win_valid)
  );

  // Select the current owner's slices; only meaningful while granted.
  always_comb begin
    owner_req = 1'b0;
    mux_we    = 1'b0;
    mux_addr  = '0;
    mux_wd    = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (owner_q == OW'(k)) begin
        owner_req = bus.i_Request[k];
        mux_we    = bus.i_Write_Enable[k];
        mux_addr  = bus.i_Address[k*memory_size_log +: memory_size_log];
        mux_wd    = bus.i_Write_Data[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q   <= s_Idle;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        s_Idle, s_Turnaround: begin
          if (win_valid) begin
            state_q <= s_Granted;
            grant_q <= N_REQ'(1) << win;
            owner_q <= win;
            hold_q  <= '0;
          end else begin
            state_q <= s_Idle;
            grant_q <= '0;
          end
        end
        s_Granted: begin
          if (!owner_req) begin
            state_q <= s_Turnaround;
            grant_q <= '0;
            owner_q <= '0;
            ptr_q   <= OW'(wrap_index(int'(owner_q) + 1, N_REQ));
          end else if (hold_q != HW'(MAX_HOLD)) begin
            // Flag is raised on the same edge the counter reaches MAX_HOLD.
            hold_q <= hold_q + 1'b1;
            if (hold_q == HW'(MAX_HOLD - 1)) begin
              timeout_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= s_Idle;
          grant_q <= '0;
          owner_q <= '0;
        end
      endcase
    end
  end

  assign granted = (state_q == s_Granted);

  // A release cycle (owner request already low) must not write.
  assign bus.o_Memory_Write_Enable = granted & owner_req & mux_we;
  assign bus.o_Memory_Address      = granted ? mux_addr : '0;
  assign bus.o_Memory_Write_Data   = granted ? mux_wd : '0;
  assign bus.o_Read_Data           = bus.i_Memory_Read_Data;
  assign bus.o_Grant               = grant_q;
  assign bus.o_Busy                = |grant_q;
  assign bus.o_Owner               = owner_q;
  assign bus.o_Timeout             = timeout_q;
  assign bus.dbg_State             = state_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter: a PRIORITY_0=1 instance (pa) and a pure
// round-robin instance (rr) share one stimulus bus.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;

  localparam int N  = 5;
  localparam int AW = 10;
  localparam int DW = 32;

  logic i_Clock;
  logic i_Reset;
  int   vectors;
  int   miscompares;

  memory_arbiter_if #(.N_REQ(N), .memory_size_log(AW), .DATA_WIDTH(DW)) pa_if ();
  memory_arbiter_if #(.N_REQ(N), .memory_size_log(AW), .DATA_WIDTH(DW)) rr_if ();

  assign rr_if.i_Request          = pa_if.i_Request;
  assign rr_if.i_Address          = pa_if.i_Address;
  assign rr_if.i_Write_Enable     = pa_if.i_Write_Enable;
  assign rr_if.i_Write_Data       = pa_if.i_Write_Data;
  assign rr_if.i_Memory_Read_Data = pa_if.i_Memory_Read_Data;

  memory_arbiter #(.N_REQ(N), .memory_size_log(AW), .DATA_WIDTH(DW),
                   .PRIORITY_0(1), .MAX_HOLD(255)) dut_pa (
    .i_Clock (i_Clock), .i_Reset (i_Reset), .bus (pa_if));

  memory_arbiter #(.N_REQ(N), .memory_size_log(AW), .DATA_WIDTH(DW),
                   .PRIORITY_0(0), .MAX_HOLD(255)) dut_rr (
    .i_Clock (i_Clock), .i_Reset (i_Reset), .bus (rr_if));

  // ---------------- clock / reset ----------------
  initial begin
    i_Clock = 1'b0;
    forever #5 i_Clock = ~i_Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge i_Clock);
    #2;
  endtask

  task automatic clear_inputs();
    pa_if.i_Request          = '0;
    pa_if.i_Address          = '0;
    pa_if.i_Write_Enable     = '0;
    pa_if.i_Write_Data       = '0;
    pa_if.i_Memory_Read_Data = '0;
  endtask

  task automatic do_reset();
    i_Reset = 1'b1;
    clear_inputs();
    @(posedge i_Clock);
    #2;
    i_Reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_Reset = 1'b1;
    clear_inputs();
    #3;
    vectors++; if (pa_if.o_Grant !== 5'b00000) begin miscompares++; $display("FAIL rst_grant got=%b exp=00000", pa_if.o_Grant); end
    vectors++; if (pa_if.o_Owner !== 3'd0) begin miscompares++; $display("FAIL rst_owner got=%0d exp=0", pa_if.o_Owner); end
    vectors++; if (pa_if.o_Busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy got=%b exp=0", pa_if.o_Busy); end
    vectors++; if (pa_if.o_Timeout !== 1'b0) begin miscompares++; $display("FAIL rst_timeout got=%b exp=0", pa_if.o_Timeout); end
    vectors++; if (pa_if.o_Memory_Address !== 10'd0) begin miscompares++; $display("FAIL rst_addr got=%0d exp=0", pa_if.o_Memory_Address); end
    vectors++; if (pa_if.o_Memory_Write_Enable !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%b exp=0", pa_if.o_Memory_Write_Enable); end
    vectors++; if (pa_if.dbg_State !== s_Idle) begin miscompares++; $display("FAIL rst_state got=%0d exp=%0d", pa_if.dbg_State, s_Idle); end
    @(posedge i_Clock);
    #2;
    i_Reset = 1'b0;
  endtask

  task automatic test_single_access();
    do_reset();
    pa_if.i_Request               = 5'b00001;
    pa_if.i_Address[0*AW +: AW]   = 10'd3;
    pa_if.i_Memory_Read_Data      = 32'h1234_5678;
    #1;
    vectors++; if (pa_if.o_Grant !== 5'b00000) begin miscompares++; $display("FAIL t1_pre_grant got=%b exp=00000", pa_if.o_Grant); end
    vectors++; if (pa_if.o_Read_Data !== 32'h1234_5678) begin miscompares++; $display("FAIL t1_rdata got=%h exp=12345678", pa_if.o_Read_Data); end
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00001) begin miscompares++; $display("FAIL t1_grant got=%b exp=00001", pa_if.o_Grant); end
    vectors++; if (pa_if.o_Busy !== 1'b1) begin miscompares++; $display("FAIL t1_busy got=%b exp=1", pa_if.o_Busy); end
    vectors++; if (pa_if.o_Memory_Address !== 10'd3) begin miscompares++; $display("FAIL t1_addr got=%0d exp=3", pa_if.o_Memory_Address); end
    for (int c = 2; c <= 4; c++) begin
      step();
      vectors++; if (pa_if.o_Memory_Address !== 10'd3) begin miscompares++; $display("FAIL t1_addr_hold cyc=%0d got=%0d exp=3", c, pa_if.o_Memory_Address); end
    end
    pa_if.i_Request = 5'b00000;
    step();
    vectors++; if (pa_if.o_Busy !== 1'b0) begin miscompares++; $display("FAIL t1_ta_busy got=%b exp=0", pa_if.o_Busy); end
    vectors++; if (pa_if.o_Memory_Address !== 10'd0) begin miscompares++; $display("FAIL t1_ta_addr got=%0d exp=0", pa_if.o_Memory_Address); end
    vectors++; if (pa_if.dbg_State !== s_Turnaround) begin miscompares++; $display("FAIL t1_ta_state got=%0d exp=%0d", pa_if.dbg_State, s_Turnaround); end
    step();
    vectors++; if (pa_if.dbg_State !== s_Idle) begin miscompares++; $display("FAIL t1_idle_state got=%0d exp=%0d", pa_if.dbg_State, s_Idle); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    pa_if.i_Request = 5'b00110;
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00010) begin miscompares++; $display("FAIL t2_first got=%b exp=00010", pa_if.o_Grant); end
    vectors++; if (pa_if.o_Owner !== 3'd1) begin miscompares++; $display("FAIL t2_owner got=%0d exp=1", pa_if.o_Owner); end
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00010) begin miscompares++; $display("FAIL t2_no_switch got=%b exp=00010", pa_if.o_Grant); end
    pa_if.i_Request = 5'b00100;
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00000) begin miscompares++; $display("FAIL t2_gap got=%b exp=00000", pa_if.o_Grant); end
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00100) begin miscompares++; $display("FAIL t2_second got=%b exp=00100", pa_if.o_Grant); end
    vectors++; if (pa_if.o_Owner !== 3'd2) begin miscompares++; $display("FAIL t2_owner2 got=%0d exp=2", pa_if.o_Owner); end
  endtask

  task automatic test_round_robin();
    int          exp_order [5];
    logic [4:0]  exp_g;
    exp_order = '{1, 2, 3, 4, 1};
    do_reset();
    pa_if.i_Request = 5'b11110;
    step();
    for (int i = 0; i < 5; i++) begin
      exp_g = 5'b00001 << exp_order[i];
      vectors++; if (rr_if.o_Grant !== exp_g) begin miscompares++; $display("FAIL t3_rr_order i=%0d got=%b exp=%b", i, rr_if.o_Grant, exp_g); end
      vectors++; if (pa_if.o_Grant !== exp_g) begin miscompares++; $display("FAIL t3_pa_order i=%0d got=%b exp=%b", i, pa_if.o_Grant, exp_g); end
      step();
      pa_if.i_Request[exp_order[i]] = 1'b0;
      step();
      vectors++; if (rr_if.o_Busy !== 1'b0) begin miscompares++; $display("FAIL t3_gap i=%0d got=%b exp=0", i, rr_if.o_Busy); end
      pa_if.i_Request[exp_order[i]] = 1'b1;
      step();
    end
  endtask

  task automatic test_timeout();
    logic exp_to;
    do_reset();
    pa_if.i_Request = 5'b01000;
    step();
    vectors++; if (pa_if.o_Timeout !== 1'b0) begin miscompares++; $display("FAIL t4_to_start got=%b exp=0", pa_if.o_Timeout); end
    for (int c = 1; c < 300; c++) begin
      step();
      exp_to = (c >= 255);
      vectors++; if (pa_if.o_Grant !== 5'b01000) begin miscompares++; $display("FAIL t4_grant c=%0d got=%b exp=01000", c, pa_if.o_Grant); end
      vectors++; if (pa_if.o_Timeout !== exp_to) begin miscompares++; $display("FAIL t4_timeout c=%0d got=%b exp=%b", c, pa_if.o_Timeout, exp_to); end
    end
    pa_if.i_Request = 5'b00000;
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00000) begin miscompares++; $display("FAIL t4_release got=%b exp=00000", pa_if.o_Grant); end
    vectors++; if (pa_if.o_Timeout !== 1'b1) begin miscompares++; $display("FAIL t4_sticky got=%b exp=1", pa_if.o_Timeout); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    pa_if.i_Request               = 5'b00100;
    pa_if.i_Write_Enable          = 5'b00100;
    pa_if.i_Write_Data[2*DW +: DW] = 32'hDEAD_BEEF;
    step();
    vectors++; if (pa_if.o_Memory_Write_Enable !== 1'b1) begin miscompares++; $display("FAIL t5_we got=%b exp=1", pa_if.o_Memory_Write_Enable); end
    vectors++; if (pa_if.o_Memory_Write_Data !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL t5_wd got=%h exp=deadbeef", pa_if.o_Memory_Write_Data); end
    pa_if.i_Request = 5'b00000;
    #1;
    vectors++; if (pa_if.o_Memory_Write_Enable !== 1'b0) begin miscompares++; $display("FAIL t5_we_gated got=%b exp=0", pa_if.o_Memory_Write_Enable); end
    step();
    pa_if.i_Request = 5'b00100;
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00100) begin miscompares++; $display("FAIL t5_regrant got=%b exp=00100", pa_if.o_Grant); end
    #1;
    i_Reset = 1'b1;
    #1;
    vectors++; if (pa_if.o_Grant !== 5'b00000) begin miscompares++; $display("FAIL t5_async_grant got=%b exp=00000", pa_if.o_Grant); end
    vectors++; if (pa_if.o_Memory_Write_Enable !== 1'b0) begin miscompares++; $display("FAIL t5_async_we got=%b exp=0", pa_if.o_Memory_Write_Enable); end
    vectors++; if (pa_if.o_Memory_Write_Data !== 32'h0) begin miscompares++; $display("FAIL t5_async_wd got=%h exp=0", pa_if.o_Memory_Write_Data); end
    vectors++; if (pa_if.o_Timeout !== 1'b0) begin miscompares++; $display("FAIL t5_to_clear got=%b exp=0", pa_if.o_Timeout); end
    pa_if.i_Request = 5'b10100;
    @(negedge i_Clock);
    i_Reset = 1'b0;
    step();
    vectors++; if (rr_if.o_Grant !== 5'b00100) begin miscompares++; $display("FAIL t5_ptr0 got=%b exp=00100", rr_if.o_Grant); end
  endtask

  task automatic test_no_preempt();
    do_reset();
    pa_if.i_Request = 5'b10000;
    step();
    vectors++; if (pa_if.o_Grant !== 5'b10000) begin miscompares++; $display("FAIL t6_own4 got=%b exp=10000", pa_if.o_Grant); end
    pa_if.i_Request = 5'b10001;
    step();
    vectors++; if (pa_if.o_Grant !== 5'b10000) begin miscompares++; $display("FAIL t6_nopreempt got=%b exp=10000", pa_if.o_Grant); end
    step();
    vectors++; if (pa_if.o_Owner !== 3'd4) begin miscompares++; $display("FAIL t6_owner got=%0d exp=4", pa_if.o_Owner); end
    pa_if.i_Request = 5'b00001;
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00000) begin miscompares++; $display("FAIL t6_gap got=%b exp=00000", pa_if.o_Grant); end
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00001) begin miscompares++; $display("FAIL t6_req0 got=%b exp=00001", pa_if.o_Grant); end
  endtask

  task automatic test_priority_override();
    do_reset();
    pa_if.i_Request = 5'b00010;
    step();
    pa_if.i_Request = 5'b00000;
    step();
    pa_if.i_Request = 5'b01001;
    step();
    vectors++; if (pa_if.o_Grant !== 5'b00001) begin miscompares++; $display("FAIL t7_pa_grant got=%b exp=00001", pa_if.o_Grant); end
    vectors++; if (rr_if.o_Grant !== 5'b01000) begin miscompares++; $display("FAIL t7_rr_grant got=%b exp=01000", rr_if.o_Grant); end
    vectors++; if (rr_if.o_Owner !== 3'd3) begin miscompares++; $display("FAIL t7_rr_owner got=%0d exp=3", rr_if.o_Owner); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_access();
    test_simultaneous();
    test_round_robin();
    test_timeout();
    test_reset_mid_grant();
    test_no_preempt();
    test_priority_override();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
Name: memory_arbiter

Overview:
- Round-robin arbiter for the coprocessor's shared data memory.
- Requesters are the main control unit (requester 0) and the p processing units (requesters 1..p).
- Grants exclusive memory ownership and muxes the owner's address, write enable and write data onto the single memory port.
- Broadcasts read data to all requesters, enforces a one-cycle bus turnaround between owners, and flags over-long grant holds.

Parameters:
- N_REQ, 5, number of requesters (p + 1); requester 0 is the main control unit.
- memory_size_log, 10, memory address width.
- DATA_WIDTH, 32, memory word width.
- PRIORITY_0, 1, 1: requester 0 wins any arbitration it takes part in; 0: pure round-robin.
- MAX_HOLD, 255, grant-hold cycle count that sets the timeout flag.

Ports:
- i_Clock  input  1  system clock, rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Request  input  N_REQ  per-requester grant request, level, held for the whole access.
- i_Address  input  N_REQ*memory_size_log  flattened addresses; requester k occupies slice k.
- i_Write_Enable  input  N_REQ  per-requester write enable.
- i_Write_Data  input  N_REQ*DATA_WIDTH  flattened write data.
- i_Memory_Read_Data  input  DATA_WIDTH  data returned by memory.
- o_Grant  output  N_REQ  one-hot grant, registered.
- o_Memory_Address  output  memory_size_log  muxed owner address.
- o_Memory_Write_Enable  output  1  muxed owner write enable, gated by grant.
- o_Memory_Write_Data  output  DATA_WIDTH  muxed owner write data.
- o_Read_Data  output  DATA_WIDTH  i_Memory_Read_Data passed through to all requesters.
- o_Busy  output  1  1 while any grant is active.
- o_Owner  output  $clog2(N_REQ)  index of current owner; 0 when idle.
- o_Timeout  output  1  sticky: some grant was held for MAX_HOLD cycles.

Behaviour:
- Reset (async, i_Reset=1), all take effect immediately:
  - o_Grant=0, o_Owner=0, o_Busy=0, o_Timeout=0.
  - Memory outputs = 0.
  - Round-robin pointer r_Pointer=0, hold counter=0, state=s_Idle.
  - Reset mid-grant drops the grant at once; the in-flight access is abandoned.
- States: s_Idle, s_Granted, s_Turnaround.
- Arbitration (evaluated in s_Idle and s_Turnaround):
  - If PRIORITY_0=1 and i_Request[0]=1, the winner is 0.
  - Otherwise the winner is the first k with i_Request[k]=1, scanning r_Pointer, r_Pointer+1, ... modulo N_REQ.
  - With no requests, go to / stay in s_Idle.
- s_Idle: on a winner, register o_Grant=one-hot(winner) and o_Owner=winner, clear the hold counter, go to s_Granted. Latency from request to grant: 1 clock.
- s_Granted:
  - Memory outputs combinationally select the slices of o_Owner.
  - o_Memory_Write_Enable = i_Write_Enable[o_Owner].
  - Requests from non-owners are ignored and remain pending.
  - Hold counter increments each cycle and saturates at MAX_HOLD; reaching MAX_HOLD sets o_Timeout.
  - Timeout does not preempt the owner.
- Release: when i_Request[o_Owner]=0 in s_Granted:
  - next edge: o_Grant=0, r_Pointer=(o_Owner+1) mod N_REQ, state=s_Turnaround.
  - the owner's write enable is ignored in that release cycle only if its request is already low; the write is gated by the request.
- s_Turnaround:
  - one cycle with no grant.
  - memory address=0, write enable=0, write data=0.
  - arbitration runs; the winner is granted at the next edge. Minimum gap between two owners: 1 idle bus cycle.
- Outside s_Granted: o_Memory_Write_Enable=0 and o_Memory_Address=0 always.
- o_Busy = |o_Grant.
- o_Read_Data is combinational from i_Memory_Read_Data and is never gated; each requester qualifies it with its own grant.
- Owner keeps its request across a re-arbitration point: no re-arbitration occurs; ownership continues indefinitely.
- Simultaneous requests at the same edge: resolved purely by the arbitration rule; exactly one grant.
- Requests by unused indices are always 0 by construction; no special handling.

Decomposition:
- Shared package (coproc_pkg): state encodings s_Idle/s_Granted/s_Turnaround, DATA_WIDTH, memory_size_log, and the N_REQ = p+1 relation.
- One sub-module, rr_priority_picker: combinational first-set search from a rotating pointer with optional fixed-priority override; outputs winner index and valid.

Test Plan:
- Reset then i_Request=5'b00001, held 4 cycles, address 3: o_Grant=00001 one clock after the request; o_Memory_Address=3 while granted; after the drop, one turnaround cycle with o_Busy=0.
- i_Request=5'b00110 together, PRIORITY_0=1, r_Pointer=0: requester 1 granted first; on release, one idle cycle, then requester 2 granted.
- All of 1..4 request continuously, each releasing after 2 cycles, PRIORITY_0=0: grant order 1,2,3,4,1.
- Requester 3 holds for 300 cycles with MAX_HOLD=255: o_Timeout=1 from grant cycle 255 onward; o_Grant stays 01000 until release; o_Timeout stays 1 after release.
- Requester 2 writing with i_Write_Enable[2]=1, data 32'hDEADBEEF, i_Reset pulsed mid-grant: o_Grant, o_Memory_Write_Enable and o_Memory_Write_Data drop to 0 asynchronously; after reset deasserts, re-arbitration starts from pointer 0.
- Requester 0 asserts while requester 4 owns the bus: no preemption; requester 0 is granted in the cycle after requester 4's turnaround.
